// File: rtl/logic_axi4_stream_upsizer_packer_if.sv
// AXI4-Stream bundle used on both sides of the upsizer packer.
// The widths are set per instance, so one definition serves the narrow rx side and the wide tx side.
interface logic_axi4_stream_upsizer_packer_if #(
  parameter int DATA_BYTES = 1,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1
);
  logic                    tvalid;
  logic                    tready;
  logic [8*DATA_BYTES-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic [USER_WIDTH-1:0]   tuser;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [ID_WIDTH-1:0]     tid;
  logic                    tlast;

  modport master (output tvalid, tdata, tkeep, tuser, tdest, tid, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tuser, tdest, tid, tlast, output tready);
endinterface

// File: rtl/logic_axi4_stream_upsizer_packer.sv
// AXI4-Stream upsizer: packs up to RATIO narrow rx beats into one wide tx beat, closing words early
// on tlast, on a tdest/tid change, or (with LOGIC_AXI4_STREAM_UPSIZER_PACKER_TIMEOUT_EN) after an idle timeout.
//
// state | meaning
// FILL  | collecting rx beats into the word registers, tx_tvalid low
// HOLD  | closed word presented on tx, waiting for tx_tready
module logic_axi4_stream_upsizer_packer #(
  parameter int RX_TDATA_BYTES = 1,
  parameter int RATIO          = 4,
  parameter int TUSER_WIDTH    = 1,
  parameter int TDEST_WIDTH    = 1,
  parameter int TID_WIDTH      = 1,
  parameter int USE_TLAST      = 1,
  parameter int USE_TKEEP      = 1,
  parameter int TIMEOUT        = 256
) (
  input  logic                                      aclk,
  input  logic                                      areset,
  logic_axi4_stream_upsizer_packer_if.slave         rx,
  logic_axi4_stream_upsizer_packer_if.master        tx
);
  localparam int LANE_W   = 8 * RX_TDATA_BYTES;
  localparam int TX_BYTES = RX_TDATA_BYTES * RATIO;
  localparam int CNT_W    = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  if (RATIO < 2) begin : g_bad_ratio
    $error("logic_axi4_stream_upsizer_packer: RATIO must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("logic_axi4_stream_upsizer_packer: TIMEOUT must be at least 1");
  end

  typedef enum logic {FILL, HOLD} state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [8*TX_BYTES-1:0]        data_q, data_d;
  logic [TX_BYTES-1:0]          keep_q, keep_d;
  logic [RATIO*TUSER_WIDTH-1:0] user_q, user_d;
  logic [TDEST_WIDTH-1:0]       dest_q;
  logic [TID_WIDTH-1:0]         id_q;
  logic                         last_q, last_d;

  logic                         sw, rdy, acc, fresh, closing, timeout_hit, tlast_eff;
  logic [RX_TDATA_BYTES-1:0]    keep_eff;

  assign tlast_eff = (USE_TLAST != 0) ? rx.tlast : 1'b0;
  assign keep_eff  = (USE_TKEEP != 0) ? rx.tkeep : '1;

  // count_q is always zero in HOLD, so it doubles as the lane index for the beat accepted on handover.
  assign sw      = (state_q == FILL) && (count_q != '0) && rx.tvalid &&
                   ((rx.tdest != dest_q) || (rx.tid != id_q));
  assign rdy     = ((state_q == FILL) || tx.tready) && !sw;
  assign acc     = rx.tvalid && rdy;
  assign fresh   = (count_q == '0);
  assign closing = (count_q == LAST_LANE) || tlast_eff;

`ifdef LOGIC_AXI4_STREAM_UPSIZER_PACKER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] timer_q;
  logic             idle;

  assign idle        = (state_q == FILL) && (count_q != '0) && !acc && !sw;
  assign timeout_hit = idle && (timer_q == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      timer_q <= '0;
    end else if (!idle || timeout_hit) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= FILL;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    last_d  = last_q;
    unique case (state_q)
      FILL: begin
        if (sw || timeout_hit) begin
          state_d = HOLD;
          count_d = '0;
          last_d  = 1'b0;
        end else if (acc) begin
          last_d = tlast_eff;
          if (closing) begin
            state_d = HOLD;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (tx.tready) begin
          if (acc) begin
            // Handover: the departing word is replaced by a fresh one holding this beat in lane 0.
            last_d = tlast_eff;
            if (!closing) begin
              state_d = FILL;
              count_d = CNT_W'(1);
            end
          end else begin
            state_d = FILL;
          end
        end
      end
    endcase
  end

  always_comb begin
    data_d = fresh ? '0 : data_q;
    keep_d = fresh ? '0 : keep_q;
    user_d = fresh ? '0 : user_q;
    for (int k = 0; k < RATIO; k++) begin
      if (count_q == CNT_W'(k)) begin
        data_d[k*LANE_W +: LANE_W]                 = rx.tdata;
        keep_d[k*RX_TDATA_BYTES +: RX_TDATA_BYTES] = keep_eff;
        user_d[k*TUSER_WIDTH +: TUSER_WIDTH]       = rx.tuser;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      data_q <= '0;
      keep_q <= '0;
      user_q <= '0;
      dest_q <= '0;
      id_q   <= '0;
      last_q <= 1'b0;
    end else begin
      if (acc) begin
        data_q <= data_d;
        keep_q <= keep_d;
        user_q <= user_d;
        if (fresh) begin
          dest_q <= rx.tdest;
          id_q   <= rx.tid;
        end
      end
      last_q <= last_d;
    end
  end

  assign rx.tready = rdy;
  assign tx.tvalid = (state_q == HOLD);
  assign tx.tdata  = data_q;
  assign tx.tkeep  = keep_q;
  assign tx.tuser  = user_q;
  assign tx.tdest  = dest_q;
  assign tx.tid    = id_q;
  assign tx.tlast  = last_q;
endmodule

// File: tb/tb_logic_axi4_stream_upsizer_packer.sv
// Directed bench for the AXI4-Stream upsizer packer (RX 1 byte, RATIO 4, TIMEOUT 8).
// Expected tx words are queued before their rx beats are driven and compared when the DUT transfers them.
module tb_logic_axi4_stream_upsizer_packer;
`ifdef LOGIC_AXI4_STREAM_UPSIZER_PACKER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic aclk;
  logic areset;
  int   checks = 0;
  int   errors = 0;

  logic_axi4_stream_upsizer_packer_if #(.DATA_BYTES(1), .USER_WIDTH(1), .DEST_WIDTH(2), .ID_WIDTH(1)) rx_if ();
  logic_axi4_stream_upsizer_packer_if #(.DATA_BYTES(4), .USER_WIDTH(4), .DEST_WIDTH(2), .ID_WIDTH(1)) tx_if ();

  logic_axi4_stream_upsizer_packer #(
    .RX_TDATA_BYTES(1), .RATIO(4), .TUSER_WIDTH(1), .TDEST_WIDTH(2), .TID_WIDTH(1),
    .USE_TLAST(1), .USE_TKEEP(1), .TIMEOUT(8)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .rx     (rx_if),
    .tx     (tx_if)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [3:0]  user;
    logic [1:0]  dest;
    logic        id;
    logic        last;
  } word_t;

  word_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic [3:0] u,
                             input logic [1:0] dst, input logic i, input logic l);
    word_t w;
    w.data = d; w.keep = k; w.user = u; w.dest = dst; w.id = i; w.last = l;
    exp_q.push_back(w);
  endtask

  // Drives one rx beat and returns on the negedge after it was accepted.
  task automatic send(input logic [7:0] d, input logic k, input logic u,
                      input logic [1:0] dst, input logic i, input logic l);
    int   n = 0;
    logic taken;
    rx_if.tvalid = 1'b1;
    rx_if.tdata  = d;
    rx_if.tkeep  = k;
    rx_if.tuser  = u;
    rx_if.tdest  = dst;
    rx_if.tid    = i;
    rx_if.tlast  = l;
    forever begin
      #1;
      taken = rx_if.tready;
      @(negedge aclk);
      if (taken) break;
      n++;
      if (n > 200) begin
        chk("rx_accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    rx_if.tvalid = 1'b0;
    rx_if.tlast  = 1'b0;
  endtask

  // Transfer monitor and AXI stability check, sampled between edges.
  logic        stalled = 1'b0;
  logic [31:0] held_data;
  logic [3:0]  held_keep;
  logic        held_last;

  always @(negedge aclk) begin
    word_t w;
    #1;
    if (areset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_tvalid", tx_if.tvalid, 1'b1);
        chk("stall_tdata", tx_if.tdata, held_data);
        chk("stall_tkeep", tx_if.tkeep, held_keep);
        chk("stall_tlast", tx_if.tlast, held_last);
      end
      stalled   = tx_if.tvalid && !tx_if.tready;
      held_data = tx_if.tdata;
      held_keep = tx_if.tkeep;
      held_last = tx_if.tlast;
      if (tx_if.tvalid && tx_if.tready) begin
        chk("tx_beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          chk("tx_tdata", tx_if.tdata, w.data);
          chk("tx_tkeep", tx_if.tkeep, w.keep);
          chk("tx_tuser", tx_if.tuser, w.user);
          chk("tx_tdest", tx_if.tdest, w.dest);
          chk("tx_tid", tx_if.tid, w.id);
          chk("tx_tlast", tx_if.tlast, w.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    areset       = 1'b1;
    rx_if.tvalid = 1'b0;
    rx_if.tdata  = '0;
    rx_if.tkeep  = '0;
    rx_if.tuser  = '0;
    rx_if.tdest  = '0;
    rx_if.tid    = '0;
    rx_if.tlast  = 1'b0;
    tx_if.tready = 1'b1;

    @(negedge aclk); #1;
    chk("rst_tvalid", tx_if.tvalid, 1'b0);
    chk("rst_tdata", tx_if.tdata, 32'h0);
    chk("rst_tkeep", tx_if.tkeep, 4'h0);
    chk("rst_tlast", tx_if.tlast, 1'b0);
    chk("rst_rx_tready", rx_if.tready, 1'b1);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk); #1;
    chk("post_rst_tvalid", tx_if.tvalid, 1'b0);
    @(negedge aclk);

    // Two full words at full throughput.
    expect_word(32'h04030201, 4'hF, 4'h5, 2'd0, 1'b0, 1'b0);
    expect_word(32'h08070605, 4'hF, 4'h5, 2'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b1, 1'(i & 1), 2'd0, 1'b0, 1'b0);

    // Partial word closed by tlast.
    expect_word(32'h0000BBAA, 4'h3, 4'h2, 2'd0, 1'b0, 1'b1);
    send(8'hAA, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    send(8'hBB, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1);

    // tdest change closes a partial word; the new beat opens the next word at lane 0.
    expect_word(32'h00002211, 4'h3, 4'h0, 2'd1, 1'b0, 1'b0);
    expect_word(32'h00004433, 4'h3, 4'h0, 2'd2, 1'b0, 1'b1);
    send(8'h11, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    send(8'h22, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    send(8'h33, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    send(8'h44, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);

    // tid change, then a single-beat packet with tkeep low accepted on handover.
    expect_word(32'h00000055, 4'h1, 4'h0, 2'd0, 1'b0, 1'b0);
    expect_word(32'h00000066, 4'h0, 4'h1, 2'd0, 1'b1, 1'b1);
    send(8'h55, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    send(8'h66, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
    repeat (3) @(negedge aclk);

    // Backpressure: tx_tready low for 10 cycles while rx streams 12 beats.
    expect_word(32'h13121110, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0);
    expect_word(32'h17161514, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0);
    expect_word(32'h1B1A1918, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0);
    fork
      begin
        for (int i = 0; i < 12; i++) send(8'(8'h10 + i), 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      end
      begin
        tx_if.tready = 1'b0;
        repeat (10) @(negedge aclk);
        tx_if.tready = 1'b1;
      end
      begin
        repeat (8) @(negedge aclk);
        #1;
        chk("stall_rx_tready", rx_if.tready, 1'b0);
      end
    join
    repeat (3) @(negedge aclk);

    // Idle after a single beat: flush after 8 idle cycles only when the timeout is built in.
    if (TO_EN) begin
      expect_word(32'h0000005A, 4'h1, 4'h0, 2'd0, 1'b0, 1'b0);
      expect_word(32'h0000005B, 4'h1, 4'h0, 2'd0, 1'b0, 1'b1);
    end else begin
      expect_word(32'h00005B5A, 4'h3, 4'h0, 2'd0, 1'b0, 1'b1);
    end
    send(8'h5A, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    repeat (7) @(negedge aclk);
    #1;
    chk("idle7_tvalid", tx_if.tvalid, 1'b0);
    @(negedge aclk); #1;
    chk("idle8_tvalid", tx_if.tvalid, TO_EN);
    send(8'h5B, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    repeat (3) @(negedge aclk);

    // Reset in the middle of a word discards it.
    send(8'h71, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    send(8'h72, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    areset = 1'b1;
    @(negedge aclk); #1;
    chk("rst_mid_tvalid", tx_if.tvalid, 1'b0);
    chk("rst_mid_rx_tready", rx_if.tready, 1'b1);
    chk("rst_mid_tkeep", tx_if.tkeep, 4'h0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    expect_word(32'h84838281, 4'hF, 4'h3, 2'd0, 1'b0, 1'b0);
    send(8'h81, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    send(8'h82, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    send(8'h83, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    send(8'h84, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    repeat (2) @(negedge aclk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("final_tvalid", tx_if.tvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
